// File: rtl/inst_pair_feeder_if.sv
// Local-store instruction port: in-order word read requests and their
// responses. The feeder acts as master and the memory acts as slave.
interface inst_pair_feeder_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/inst_pair_feeder.sv
// Instruction prefetch queue. Issues credit-limited word reads and buffers the
// returned words, then presents two consecutive words per cycle to dual-issue decode.
module inst_pair_feeder #(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 4,
    parameter int          LS_BYTES = 32768,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         pc_input,
    inst_pair_feeder_if.master  imem,
    output logic                pair_valid,
    output logic [31:0]         first_inst,
    output logic [31:0]         second_inst,
    output logic [31:0]         pc_output
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] LS_MASK   = 32'(LS_BYTES - 1);
    localparam logic [CW:0] DEPTH_W   = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);

    logic [31:0]   fifo [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;

    logic [CW:0]   credit_used;
    logic          have_pair;
    logic          issue;
    logic          accept;
    logic          pop;
    logic [31:0]   target;

    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign have_pair   = (count >= CW'(2));
    assign target      = pc_input & LS_MASK & ~32'd3;

    // Request is also gated by the reset level so the port is quiet while held in reset.
    assign imem.req  = reset & ~branch_taken & (credit_used < DEPTH_W) & (outstanding < MAX_C);
    assign imem.addr = fetch_pc;
    assign issue     = imem.req & imem.gnt;

    // A full FIFO can only receive a word through a protocol error; that word is lost.
    assign accept = imem.rvalid & ~branch_taken & (drop_cnt == '0) & (count != DEPTH_C);
    assign pop    = pair_valid & ~stall;

    assign pair_valid  = have_pair & ~branch_taken;
    assign first_inst  = have_pair ? fifo[rd_ptr] : 32'd0;
    assign second_inst = have_pair ? fifo[rd_ptr + AW'(1)] : 32'd0;
    assign pc_output   = head_pc;

    always_ff @(posedge clock) begin
        if (accept) begin
            fifo[wr_ptr] <= imem.rdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
        end else if (branch_taken) begin
            // Every request still in flight returns a stale word; one arriving now is already discarded.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(imem.rvalid);
            drop_cnt    <= outstanding - CW'(imem.rvalid);
            fetch_pc    <= target;
            head_pc     <= target;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem.rvalid);
            if (imem.rvalid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            count <= count + CW'(accept) - (pop ? CW'(2) : CW'(0));
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(2);
                head_pc <= (head_pc + 32'd8) & LS_MASK;
            end
            if (issue) begin
                fetch_pc <= (fetch_pc + 32'd4) & LS_MASK;
            end
        end
    end
endmodule

// File: tb/tb_inst_pair_feeder.sv
// Bench for inst_pair_feeder: in-order memory model with variable latency and a
// pair scoreboard that tracks the expected program counter stream.
module tb_inst_pair_feeder;
    localparam int          DEPTH    = 8;
    localparam int          MAX_OUT  = 4;
    localparam int          LS_BYTES = 32768;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] LS_MASK  = 32'(LS_BYTES - 1);

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] pc_input;
    logic        pair_valid;
    logic [31:0] first_inst;
    logic [31:0] second_inst;
    logic [31:0] pc_output;

    inst_pair_feeder_if imem_bus ();

    inst_pair_feeder #(
        .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .LS_BYTES(LS_BYTES), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .pc_input(pc_input), .imem(imem_bus), .pair_valid(pair_valid),
        .first_inst(first_inst), .second_inst(second_inst), .pc_output(pc_output)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    req_t        q[$];
    int          cyc      = 0;
    int          epoch    = 0;
    int          held     = 0;
    int          lat      = 1;
    int          first_pv = -1;
    int          npairs   = 0;
    bit          stall_drv = 0;
    bit          gnt_rand  = 0;
    bit          last_req;
    bit          got_first = 0;
    logic [31:0] first_pc_after_br = '0;
    logic [31:0] exp_pc    = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h10 + ((a & LS_MASK) >> 2);
    endfunction

    // One clock cycle: drive at the falling edge, observe 1 ns later, then advance past the rising edge.
    task automatic step(input bit br, input logic [31:0] tgt_in);
        req_t        r;
        bit          rv;
        bit          exp_req;
        int          due;
        logic [31:0] tgt;
        tgt          = tgt_in & LS_MASK & ~32'd3;
        branch_taken = br;
        pc_input     = tgt_in;
        stall        = stall_drv;
        imem_bus.gnt = gnt_rand ? ($urandom_range(3) != 0) : 1'b1;
        rv = (q.size() > 0) && (q[0].due <= cyc);
        imem_bus.rvalid = rv;
        imem_bus.rdata  = rv ? mem_word(q[0].addr) : $urandom;
        #1;
        exp_req = !br && (held + q.size() < DEPTH) && (q.size() < MAX_OUT);
        last_req = imem_bus.req;
        check_eq("imem_req", 32'(imem_bus.req), 32'(exp_req));
        check_eq("pair_valid", 32'(pair_valid), 32'(!br && held >= 2));
        if (pair_valid) begin
            if (first_pv < 0) first_pv = cyc;
            check_eq("pc_output", pc_output, exp_pc);
            check_eq("first_inst", first_inst, mem_word(exp_pc));
            check_eq("second_inst", second_inst, mem_word(exp_pc + 32'd4));
        end
        if (rv) begin
            r = q.pop_front();
            if (r.epoch == epoch && !br) held++;
        end
        if (imem_bus.req && imem_bus.gnt) begin
            check_eq("imem_addr", imem_bus.addr, exp_fetch);
            due = cyc + ((lat == 0) ? int'($urandom_range(4, 1)) : lat);
            if (q.size() > 0 && due < q[$].due) due = q[$].due;
            r.addr = imem_bus.addr; r.due = due; r.epoch = epoch;
            q.push_back(r);
            exp_fetch = (exp_fetch + 32'd4) & LS_MASK;
        end
        if (pair_valid && !stall_drv) begin
            if (!got_first) begin
                first_pc_after_br = pc_output;
                got_first = 1;
            end
            held -= 2;
            npairs++;
            exp_pc = (exp_pc + 32'd8) & LS_MASK;
        end
        if (br) begin
            epoch++;
            held = 0;
            got_first = 0;
            exp_pc = tgt;
            exp_fetch = tgt;
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        int  n0;
        bit  found;
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; pc_input = '0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_req", 32'(imem_bus.req), 0);
        check_eq("rst_pv", 32'(pair_valid), 0);
        check_eq("rst_first", first_inst, 0);
        check_eq("rst_second", second_inst, 0);
        check_eq("rst_pc", pc_output, RESET_PC);

        // Streaming with 1-cycle memory: first pair at cycle 3, then one pair every 2 cycles.
        reset = 1'b1;
        cyc = 0;
        repeat (15) step(0, 0);
        check_eq("first_pv_cycle", 32'(first_pv), 3);
        check_eq("pairs_sustained", 32'(npairs), 6);

        // Long stall: fetch fills every credit then stops.
        stall_drv = 1;
        repeat (12) step(0, 0);
        check_eq("stall_req_off", 32'(last_req), 0);
        check_eq("stall_credit", 32'(held + q.size()), DEPTH);
        stall_drv = 0;
        n0 = npairs;
        repeat (20) step(0, 0);
        check_eq("resume_pairs", 32'((npairs - n0) >= 8), 1);

        // Redirect with three requests in flight on a 3-cycle memory.
        lat = 3;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (q.size() == 3) found = 1;
            else step(0, 0);
        end
        check_eq("wait_out3", 32'(found), 1);
        step(1, 32'h103);
        repeat (30) step(0, 0);
        check_eq("br_first_pc", first_pc_after_br, 32'h100);

        // Redirect coincident with a returning word while five words are queued.
        lat = 1;
        stall_drv = 1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (held == 5 && q.size() > 0 && q[0].due <= cyc) found = 1;
            else step(0, 0);
        end
        check_eq("wait_cnt5_rv", 32'(found), 1);
        step(1, 32'h2000);
        stall_drv = 0;
        repeat (20) step(0, 0);
        check_eq("br_rv_first_pc", first_pc_after_br, 32'h2000);

        // Address wrap at the top of the local store, plus back-to-back redirects.
        lat = 2;
        step(1, 32'hFFFF_7FF8);
        repeat (14) step(0, 0);
        check_eq("wrap_first_pc", first_pc_after_br, 32'h7FF8);
        step(1, 32'h40);
        step(1, 32'h8000_7FFF);
        repeat (14) step(0, 0);
        check_eq("wrap_pair_pc", first_pc_after_br, 32'h7FFC);

        // Randomized traffic.
        gnt_rand = 1;
        lat = 0;
        for (int k = 0; k < 1500; k++) begin
            stall_drv = ($urandom_range(2) == 0);
            step($urandom_range(49) == 0, $urandom);
        end

        // Asynchronous reset in the middle of a burst.
        gnt_rand = 0;
        stall_drv = 0;
        lat = 3;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (q.size() >= 2) found = 1;
            else step(0, 0);
        end
        check_eq("wait_out2", 32'(found), 1);
        #2;
        reset = 1'b0;
        imem_bus.rvalid = 1'b0;
        #1;
        check_eq("arst_req", 32'(imem_bus.req), 0);
        check_eq("arst_pv", 32'(pair_valid), 0);
        check_eq("arst_first", first_inst, 0);
        check_eq("arst_second", second_inst, 0);
        check_eq("arst_pc", pc_output, RESET_PC);
        q.delete();
        epoch++;
        held = 0;
        got_first = 0;
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
        @(negedge clock);
        reset = 1'b1;
        repeat (16) step(0, 0);
        check_eq("post_rst_pc", first_pc_after_br, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
